// File: rtl/dwconv_pkg.sv
// dwconv_pkg: shared widths, sizes and FSM state type for the depthwise 3x3 engine.
package dwconv_pkg;
    localparam int DATA_W       = 8;
    localparam int ACC_W        = 32;
    localparam int TAPS         = 9;
    localparam int TAP_W        = 4;
    localparam int WEIGHT_DEPTH = 1024;
    localparam int ADDR_WIDTH   = 10;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;

    // Full-precision int8 x int8 product; the casts sign-extend before multiplying.
    function automatic logic signed [2*DATA_W-1:0] mac_prod(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (2*DATA_W)'(a) * (2*DATA_W)'(b);
    endfunction
endpackage

// File: rtl/weight_memory.sv
// weight_memory: int8 weight store with a registered read port (1-cycle latency).
module weight_memory #(
    parameter int WEIGHT_DEPTH = 1024,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic                  read_en,
    output logic [7:0]            read_data,
    output logic                  read_valid
);
    logic [7:0] weight_mem [WEIGHT_DEPTH] = '{default: 8'h00};
    logic [7:0] read_data_q;
    logic       read_valid_q;
    logic [7:0] read_data_d;

    // Addresses past the populated depth read back as zero.
    always_comb read_data_d = (32'(read_addr) < WEIGHT_DEPTH) ? weight_mem[read_addr] : 8'h00;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
        end else if (read_en) begin
            read_data_q  <= read_data_d;
            read_valid_q <= 1'b1;
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
endmodule

// File: rtl/depthwise_conv3x3_engine.sv
// depthwise_conv3x3_engine: sequential 3x3 int8 dot product, one tap per cycle,
// result held with result_valid until clear, restart or reset.
module depthwise_conv3x3_engine
    import dwconv_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] window_in      [TAPS-1:0],
    input  logic signed [DATA_W-1:0] kernel_weights [TAPS-1:0],
    input  logic                     start_conv,
    input  logic                     clear,
    output logic signed [ACC_W-1:0]  conv_result,
    output logic                     result_valid
);
    state_e                   state_q;
    logic signed [DATA_W-1:0] win_q [TAPS-1:0];
    logic signed [DATA_W-1:0] ker_q [TAPS-1:0];
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  result_q;
    logic [TAP_W-1:0]         tap_q;
    logic                     valid_q;

    always_comb acc_d = acc_q + ACC_W'(mac_prod(win_q[tap_q], ker_q[tap_q]));

    // tap_q == TAPS is a finalize cycle that publishes the completed sum.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            win_q    <= '{default: '0};
            ker_q    <= '{default: '0};
            acc_q    <= '0;
            tap_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else if (clear) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            tap_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: if (start_conv) begin
                    win_q   <= window_in;
                    ker_q   <= kernel_weights;
                    acc_q   <= '0;
                    tap_q   <= '0;
                    valid_q <= 1'b0;
                    state_q <= MAC;
                end
                MAC: if (tap_q == TAP_W'(TAPS)) begin
                    result_q <= acc_q;
                    valid_q  <= 1'b1;
                    state_q  <= DONE;
                end else begin
                    acc_q <= acc_d;
                    tap_q <= tap_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign conv_result  = result_q;
    assign result_valid = valid_q;
endmodule

// File: tb/tb_depthwise_conv3x3_engine.sv
// tb_depthwise_conv3x3_engine: directed checks of the engine and the weight memory.
module tb_depthwise_conv3x3_engine;
    import dwconv_pkg::*;

    logic                     clock = 1'b0;
    logic                     reset = 1'b1;
    logic                     start_conv = 1'b0;
    logic                     clear = 1'b0;
    logic signed [DATA_W-1:0] window_in      [TAPS-1:0];
    logic signed [DATA_W-1:0] kernel_weights [TAPS-1:0];
    logic signed [ACC_W-1:0]  conv_result;
    logic                     result_valid;
    logic [ADDR_WIDTH-1:0]    read_addr = '0;
    logic                     read_en = 1'b0;
    logic [7:0]               read_data;
    logic                     read_valid;
    int                       n_cmp = 0;
    int                       n_bad = 0;

    always #5 clock = ~clock;

    depthwise_conv3x3_engine dut (
        .clock          (clock),
        .reset          (reset),
        .window_in      (window_in),
        .kernel_weights (kernel_weights),
        .start_conv     (start_conv),
        .clear          (clear),
        .conv_result    (conv_result),
        .result_valid   (result_valid)
    );

    weight_memory #(.WEIGHT_DEPTH(WEIGHT_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) wm (
        .clock      (clock),
        .reset      (reset),
        .read_addr  (read_addr),
        .read_en    (read_en),
        .read_data  (read_data),
        .read_valid (read_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ops(input logic [7:0] w, input logic [7:0] k, input bit ramp);
        for (int i = 0; i < TAPS; i++) begin
            window_in[i]      = w;
            kernel_weights[i] = ramp ? 8'(i + 1) : k;
        end
    endtask

    // Starts a convolution, scrambles the inputs after the start edge, optionally
    // pokes start_conv mid-MAC, and checks valid timing and the final sum.
    task automatic run_conv(input string tag, input logic [31:0] exp, input int poke);
        @(negedge clock);
        start_conv = 1'b1;
        @(posedge clock);
        #1 start_conv = 1'b0;
        set_ops(8'h55, 8'h33, 1'b0);
        for (int e = 1; e <= 9; e++) begin
            @(posedge clock);
            #1 start_conv = (e == poke);
        end
        start_conv = 1'b0;
        check({tag, "_early_valid"}, 32'(result_valid), 32'd0);
        @(posedge clock);
        #1;
        check({tag, "_valid"}, 32'(result_valid), 32'd1);
        check({tag, "_result"}, conv_result, exp);
    endtask

    task automatic fetch_kernel();
        for (int i = 0; i < TAPS; i++) begin
            @(negedge clock);
            read_en   = 1'b1;
            read_addr = ADDR_WIDTH'(i);
            @(posedge clock);
            #1 kernel_weights[i] = read_data;
        end
        @(negedge clock);
        read_en = 1'b0;
    endtask

    initial begin
        set_ops(8'd0, 8'd0, 1'b0);
        #12 reset = 1'b0;
        #1;
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_result", conv_result, 32'd0);

        set_ops(8'd10, 8'd0, 1'b1);
        run_conv("ramp", 32'd450, 0);
        repeat (5) @(posedge clock);
        #1;
        check("ramp_hold_valid", 32'(result_valid), 32'd1);
        check("ramp_hold_result", conv_result, 32'd450);

        set_ops(8'd10, 8'hFF, 1'b0);
        run_conv("neg", 32'hFFFF_FFA6, 0);

        set_ops(8'h80, 8'h80, 1'b0);
        run_conv("max_poke", 32'd147456, 3);
        repeat (3) @(posedge clock);
        #1 check("max_hold_result", conv_result, 32'd147456);

        @(negedge clock);
        clear = 1'b1;
        @(posedge clock);
        #1 clear = 1'b0;
        check("clr_valid", 32'(result_valid), 32'd0);
        check("clr_result", conv_result, 32'd0);

        set_ops(8'd10, 8'd0, 1'b1);
        @(negedge clock);
        clear = 1'b1;
        start_conv = 1'b1;
        @(posedge clock);
        #1 clear = 1'b0;
        start_conv = 1'b0;
        repeat (12) @(posedge clock);
        #1 check("clr_prio_valid", 32'(result_valid), 32'd0);

        run_conv("pre_abort", 32'd450, 0);
        set_ops(8'd10, 8'd0, 1'b1);
        @(negedge clock);
        start_conv = 1'b1;
        @(posedge clock);
        #1 start_conv = 1'b0;
        repeat (4) @(posedge clock);
        #2 reset = 1'b1;
        #3 reset = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        check("abort_valid", 32'(result_valid), 32'd0);
        check("abort_result", conv_result, 32'd0);

        check("wm_rst_valid", 32'(read_valid), 32'd0);
        @(negedge clock);
        read_en = 1'b1;
        read_addr = '0;
        @(posedge clock);
        #1;
        check("wm_rd0_valid", 32'(read_valid), 32'd1);
        check("wm_rd0_data", 32'(read_data), 32'd0);
        read_en = 1'b0;
        @(posedge clock);
        #1;
        check("wm_hold_valid", 32'(read_valid), 32'd1);
        check("wm_hold_data", 32'(read_data), 32'd0);

        set_ops(8'd10, 8'h77, 1'b0);
        fetch_kernel();
        run_conv("wm_zero", 32'd0, 0);

        for (int i = 0; i < TAPS; i++) wm.weight_mem[i] = 8'(i + 1);
        set_ops(8'd10, 8'h00, 1'b0);
        fetch_kernel();
        @(posedge clock);
        #1 check("wm_last_held", 32'(read_data), 32'd9);
        run_conv("wm_ramp", 32'd450, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
